passcode_entry_controller: RTL and testbench
============================================

Name: passcode_entry_controller

Overview:
- Upstream stage of the lock display path. Accepts debounced keypad events and assembles the entered digits into `userEntry`.
- Compares a complete entry against a stored passcode and drives `error` and `unlocked`.
- `userEntry` and `error` feed the 7-segment display state machine directly. The stored passcode can be changed while unlocked.

Parameters:
- PASSCODE_LENGTH, 4: number of digits in the unlock code.
- PASSCODE_WIDTH, 4*PASSCODE_LENGTH: bits holding the code, one BCD nibble per digit.
- DEFAULT_PASSCODE, 16'h1234 (PASSCODE_WIDTH bits): passcode loaded at reset.
- ERROR_CYCLES, 50000000: clock cycles `error` stays high after a mismatch. Must be ≥1.
- MAX_ATTEMPTS, 3: consecutive mismatches before lockout. Used only with LOCKOUT_EN.
- LOCKOUT_CYCLES, 500000000: lockout duration in cycles. Used only with LOCKOUT_EN.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- keyStrobe  in  1  single-cycle pulse: a digit key was pressed.
- keyDigit  in  4  digit value, sampled when keyStrobe=1.
- enter  in  1  single-cycle pulse: submit the entry.
- clear  in  1  single-cycle pulse: discard the entry.
- lockCmd  in  1  single-cycle pulse: relock while unlocked.
- userEntry  out  PASSCODE_WIDTH  entered digits, right-justified; unfilled nibbles = 4'hE.
- error  out  1  high while an error is being displayed.
- unlocked  out  1  high in UNLOCKED.
- lockedOut  out  1  high during lockout.

Behaviour:
- All outputs are registered; a change takes effect one cycle after the causing edge.
- Reset (asynchronous, any time, including mid-ERROR):
  - state=ENTRY; userEntry all 4'hE; digitCount=0.
  - error=0, unlocked=0, lockedOut=0.
  - passcode reg = DEFAULT_PASSCODE; attempt counter=0; timers=0.
- States: ENTRY, CHECK, ERROR, UNLOCKED, LOCKOUT (LOCKOUT only with LOCKOUT_EN).
- Digit accept (ENTRY and UNLOCKED only): keyStrobe with keyDigit≤9 and digitCount<PASSCODE_LENGTH:
  - userEntry <= {userEntry[PASSCODE_WIDTH-5:0], keyDigit}; digitCount+1.
  - keyDigit>9 is ignored.
  - A strobe when digitCount==PASSCODE_LENGTH is ignored (no wrap, no shift).
- Same-cycle priority: clear > enter > keyStrobe; lower-priority events that cycle are dropped.
- clear: userEntry all 4'hE, digitCount=0; state unchanged.
- ENTRY:
  - enter with digitCount==PASSCODE_LENGTH -> CHECK.
  - enter with a partial entry is ignored.
- CHECK (exactly 1 cycle):
  - userEntry==passcode: -> UNLOCKED; unlocked=1; attempts=0; entry cleared.
  - Otherwise: -> ERROR; error=1; timer=ERROR_CYCLES-1; attempts+1 (saturating).
- ERROR:
  - All key inputs are ignored; timer decrements each cycle.
  - On the cycle timer==0: -> ENTRY; error=0; entry cleared.
  - `error` is high for exactly ERROR_CYCLES cycles.
- UNLOCKED:
  - enter with a full entry: passcode <= userEntry, entry cleared, unlocked=0, -> ENTRY.
  - lockCmd: unlocked=0, entry cleared, -> ENTRY; passcode unchanged.
  - If lockCmd and enter arrive together, lockCmd wins.
  - lockCmd in any other state is ignored.
- Entry contents persist unchanged through an enter with a partial entry.

Optional Feature:
- Macro: LOCKOUT_EN.
- Defined:
  - When ERROR expires with attempts==MAX_ATTEMPTS -> LOCKOUT instead of ENTRY.
  - In LOCKOUT: error=1 and lockedOut=1 for LOCKOUT_CYCLES cycles; all inputs ignored.
  - Then -> ENTRY, attempts=0, error=0, lockedOut=0.
  - A successful unlock clears attempts.
- Undefined: no LOCKOUT state or lockout counter; unlimited attempts; lockedOut tied 0.

Test Plan (ERROR_CYCLES=8, LOCKOUT_CYCLES=16 overridden):
- Reset, then strobe digits 1,2,3,4, then enter.
  - userEntry steps EEE1 -> EE12 -> E123 -> 1234.
  - unlocked=1 two cycles after enter; userEntry returns to EEEE.
- Strobes 5,5,5,5, then enter.
  - error=1 for exactly 8 cycles, then userEntry=EEEE and state=ENTRY.
  - Strobes during ERROR leave userEntry unchanged.
- Boundary inputs:
  - Strobe 1,2,3 then enter -> ignored; userEntry stays E123.
  - Strobe keyDigit=4'hA -> ignored.
  - Fifth digit after 1234 -> ignored.
  - clear+enter in the same cycle -> userEntry=EEEE, no CHECK.
- Unlock with 1234, enter 9876+enter -> locked.
  - 1234 now gives error.
  - 9876 now unlocks.
  - lockCmd -> unlocked=0.
- Assert reset at cycle 3 of ERROR -> error=0 immediately (asynchronous); passcode back to 1234.
- LOCKOUT_EN: three wrong entries -> after the 3rd ERROR, lockedOut=1 and error=1 for 16 cycles; then the correct code unlocks.

Source files
------------

// File: rtl/passcode_entry_controller.sv
// passcode_entry_controller
//   Collects debounced keypad digits into a right-justified BCD entry.
//   Each unfilled nibble reads 4'hE. A complete entry is compared with
//   the stored passcode. The passcode can be rewritten while unlocked.
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-high reset
//   keyStrobe  one-cycle pulse: a digit key was pressed (keyDigit valid)
//   keyDigit   digit value; codes above 9 are ignored
//   enter      one-cycle pulse: submit the entry
//   clear      one-cycle pulse: discard the entry
//   lockCmd    one-cycle pulse: relock while unlocked
//   userEntry  entered digits, right-justified, unfilled nibbles 4'hE
//   error      high while a mismatch (or lockout) is being displayed
//   unlocked   high in UNLOCKED
//   lockedOut  high during lockout (tied low unless LOCKOUT_EN)
//
// Optional feature: define LOCKOUT_EN to lock the keypad for LOCKOUT_CYCLES
// cycles after MAX_ATTEMPTS consecutive mismatches.
//
// state    | meaning
// ENTRY    | collecting digits, locked
// CHECK    | one-cycle compare of entry against passcode
// ERROR    | mismatch shown for ERROR_CYCLES cycles, keys ignored
// UNLOCKED | open; a full entry + enter stores a new passcode
// LOCKOUT  | too many mismatches, all inputs ignored (LOCKOUT_EN only)

module passcode_entry_controller #(
  parameter int                        PASSCODE_LENGTH  = 4,
  parameter int                        PASSCODE_WIDTH   = 4 * PASSCODE_LENGTH,
  parameter logic [PASSCODE_WIDTH-1:0] DEFAULT_PASSCODE = 16'h1234,
  parameter int                        ERROR_CYCLES     = 50000000,
  parameter int                        MAX_ATTEMPTS     = 3,
  parameter int                        LOCKOUT_CYCLES   = 500000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      keyStrobe,
  input  logic [3:0]                keyDigit,
  input  logic                      enter,
  input  logic                      clear,
  input  logic                      lockCmd,
  output logic [PASSCODE_WIDTH-1:0] userEntry,
  output logic                      error,
  output logic                      unlocked,
  output logic                      lockedOut
);

  localparam int                        CW          = $clog2(PASSCODE_LENGTH + 1);
  localparam logic [CW-1:0]             FULL_COUNT  = CW'(PASSCODE_LENGTH);
  localparam logic [PASSCODE_WIDTH-1:0] BLANK_ENTRY = {PASSCODE_LENGTH{4'hE}};
  localparam logic [31:0]               ERROR_LOAD  = 32'(ERROR_CYCLES - 1);

  if (ERROR_CYCLES < 1 || LOCKOUT_CYCLES < 1 || MAX_ATTEMPTS < 1) begin : g_param_check
    $error("passcode_entry_controller: cycle counts and MAX_ATTEMPTS must be >= 1");
  end

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_ERROR,
`ifdef LOCKOUT_EN
    S_LOCKOUT,
`endif
    S_UNLOCKED
  } state_t;

  state_t                    state_q, state_d;
  logic [PASSCODE_WIDTH-1:0] entry_q, entry_d;
  logic [PASSCODE_WIDTH-1:0] passcode_q, passcode_d;
  logic [CW-1:0]             count_q, count_d;
  logic [31:0]               timer_q, timer_d;
  logic                      error_q, error_d;
  logic                      unlocked_q, unlocked_d;
  logic                      digit_ok;
  logic                      entry_full;

`ifdef LOCKOUT_EN
  localparam int             AW           = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [AW-1:0]  MAX_ATT      = AW'(MAX_ATTEMPTS);
  localparam logic [31:0]    LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);
  logic [AW-1:0]             attempts_q, attempts_d;
  logic                      locked_out_q, locked_out_d;
`endif

  assign digit_ok   = keyStrobe && (keyDigit <= 4'd9) && (count_q < FULL_COUNT);
  assign entry_full = (count_q == FULL_COUNT);

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    passcode_d = passcode_q;
    count_d    = count_q;
    timer_d    = timer_q;
    error_d    = error_q;
    unlocked_d = unlocked_q;
`ifdef LOCKOUT_EN
    attempts_d   = attempts_q;
    locked_out_d = locked_out_q;
`endif
    case (state_q)
      S_ENTRY: begin
        if (clear) begin
          entry_d = BLANK_ENTRY;
          count_d = '0;
        end else if (enter) begin
          // A partial entry is left untouched so the user can keep typing.
          if (entry_full) state_d = S_CHECK;
        end else if (digit_ok) begin
          entry_d = {entry_q[PASSCODE_WIDTH-5:0], keyDigit};
          count_d = count_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (entry_q == passcode_q) begin
          state_d    = S_UNLOCKED;
          unlocked_d = 1'b1;
          entry_d    = BLANK_ENTRY;
          count_d    = '0;
`ifdef LOCKOUT_EN
          attempts_d = '0;
`endif
        end else begin
          state_d = S_ERROR;
          error_d = 1'b1;
          timer_d = ERROR_LOAD;
`ifdef LOCKOUT_EN
          if (attempts_q != MAX_ATT) attempts_d = attempts_q + 1'b1;
`endif
        end
      end
      S_ERROR: begin
        if (timer_q == '0) begin
          entry_d = BLANK_ENTRY;
          count_d = '0;
`ifdef LOCKOUT_EN
          if (attempts_q == MAX_ATT) begin
            // error stays high through the lockout window.
            state_d      = S_LOCKOUT;
            timer_d      = LOCKOUT_LOAD;
            locked_out_d = 1'b1;
          end else begin
            state_d = S_ENTRY;
            error_d = 1'b0;
          end
`else
          state_d = S_ENTRY;
          error_d = 1'b0;
`endif
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`ifdef LOCKOUT_EN
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d      = S_ENTRY;
          attempts_d   = '0;
          error_d      = 1'b0;
          locked_out_d = 1'b0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`endif
      S_UNLOCKED: begin
        if (lockCmd) begin
          state_d    = S_ENTRY;
          unlocked_d = 1'b0;
          entry_d    = BLANK_ENTRY;
          count_d    = '0;
        end else if (clear) begin
          entry_d = BLANK_ENTRY;
          count_d = '0;
        end else if (enter) begin
          if (entry_full) begin
            passcode_d = entry_q;
            state_d    = S_ENTRY;
            unlocked_d = 1'b0;
            entry_d    = BLANK_ENTRY;
            count_d    = '0;
          end
        end else if (digit_ok) begin
          entry_d = {entry_q[PASSCODE_WIDTH-5:0], keyDigit};
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = S_ENTRY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_ENTRY;
      entry_q      <= BLANK_ENTRY;
      passcode_q   <= DEFAULT_PASSCODE;
      count_q      <= '0;
      timer_q      <= '0;
      error_q      <= 1'b0;
      unlocked_q   <= 1'b0;
`ifdef LOCKOUT_EN
      attempts_q   <= '0;
      locked_out_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      passcode_q   <= passcode_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      error_q      <= error_d;
      unlocked_q   <= unlocked_d;
`ifdef LOCKOUT_EN
      attempts_q   <= attempts_d;
      locked_out_q <= locked_out_d;
`endif
    end
  end

  assign userEntry = entry_q;
  assign error     = error_q;
  assign unlocked  = unlocked_q;
`ifdef LOCKOUT_EN
  assign lockedOut = locked_out_q;
`else
  assign lockedOut = 1'b0;
`endif

endmodule

// File: tb/tb_passcode_entry_controller.sv
module tb_passcode_entry_controller;

  logic        clock;
  logic        reset;
  logic        keyStrobe;
  logic [3:0]  keyDigit;
  logic        enter;
  logic        clear;
  logic        lockCmd;
  logic [15:0] userEntry;
  logic        error;
  logic        unlocked;
  logic        lockedOut;

  int total = 0;
  int bad   = 0;

  passcode_entry_controller #(
    .PASSCODE_LENGTH (4),
    .PASSCODE_WIDTH  (16),
    .DEFAULT_PASSCODE(16'h1234),
    .ERROR_CYCLES    (8),
    .MAX_ATTEMPTS    (3),
    .LOCKOUT_CYCLES  (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .keyStrobe(keyStrobe),
    .keyDigit (keyDigit),
    .enter    (enter),
    .clear    (clear),
    .lockCmd  (lockCmd),
    .userEntry(userEntry),
    .error    (error),
    .unlocked (unlocked),
    .lockedOut(lockedOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    keyStrobe = 1'b1;
    keyDigit  = d;
    tick();
    keyStrobe = 1'b0;
    keyDigit  = 4'h0;
  endtask

  task automatic pulse_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic pulse_lock();
    lockCmd = 1'b1;
    tick();
    lockCmd = 1'b0;
  endtask

  task automatic type_code(input logic [15:0] code);
    press(code[15:12]);
    press(code[11:8]);
    press(code[7:4]);
    press(code[3:0]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (userEntry !== 16'hEEEE) begin
      bad++;
      $display("FAIL reset_entry got=%h want=%h", userEntry, 16'hEEEE);
    end
    total++;
    if ({error, unlocked, lockedOut} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000", {error, unlocked, lockedOut});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_unlock();
    logic [15:0] steps [4];
    steps[0] = 16'hEEE1; steps[1] = 16'hEE12; steps[2] = 16'hE123; steps[3] = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      press(4'(i + 1));
      total++;
      if (userEntry !== steps[i]) begin
        bad++;
        $display("FAIL unlock_step%0d got=%h want=%h", i, userEntry, steps[i]);
      end
    end
    pulse_enter();
    total++;
    if (unlocked !== 1'b0) begin
      bad++;
      $display("FAIL unlock_check_cycle got=%b want=0", unlocked);
    end
    tick();
    total++;
    if (unlocked !== 1'b1 || userEntry !== 16'hEEEE) begin
      bad++;
      $display("FAIL unlock_open got=%b/%h want=1/EEEE", unlocked, userEntry);
    end
    pulse_lock();
    total++;
    if (unlocked !== 1'b0) begin
      bad++;
      $display("FAIL unlock_relock got=%b want=0", unlocked);
    end
  endtask

  task automatic test_error();
    type_code(16'h5555);
    pulse_enter();
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL error_check_cycle got=%b want=0", error);
    end
    tick();
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL error_rise got=%b want=1", error);
    end
    for (int i = 0; i < 7; i++) begin
      press(4'h7);
      total++;
      if (error !== 1'b1 || userEntry !== 16'h5555 || lockedOut !== 1'b0) begin
        bad++;
        $display("FAIL error_hold%0d got=%b/%h/%b want=1/5555/0", i, error, userEntry, lockedOut);
      end
    end
    tick();
    total++;
    if (error !== 1'b0 || userEntry !== 16'hEEEE) begin
      bad++;
      $display("FAIL error_expire got=%b/%h want=0/EEEE", error, userEntry);
    end
    press(4'h1);
    total++;
    if (userEntry !== 16'hEEE1) begin
      bad++;
      $display("FAIL error_back_to_entry got=%h want=EEE1", userEntry);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_boundary();
    press(4'h1); press(4'h2); press(4'h3);
    pulse_enter();
    tick();
    total++;
    if (userEntry !== 16'hE123 || error !== 1'b0 || unlocked !== 1'b0) begin
      bad++;
      $display("FAIL bnd_partial_enter got=%h/%b/%b want=E123/0/0", userEntry, error, unlocked);
    end
    press(4'hA);
    total++;
    if (userEntry !== 16'hE123) begin
      bad++;
      $display("FAIL bnd_nondigit got=%h want=E123", userEntry);
    end
    press(4'h4);
    press(4'h5);
    total++;
    if (userEntry !== 16'h1234) begin
      bad++;
      $display("FAIL bnd_fifth_digit got=%h want=1234", userEntry);
    end
    clear = 1'b1;
    enter = 1'b1;
    tick();
    clear = 1'b0;
    enter = 1'b0;
    total++;
    if (userEntry !== 16'hEEEE) begin
      bad++;
      $display("FAIL bnd_clear_enter got=%h want=EEEE", userEntry);
    end
    tick();
    tick();
    total++;
    if (unlocked !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL bnd_no_check got=%b/%b want=0/0", unlocked, error);
    end
    // enter beats a same-cycle strobe
    press(4'h1); press(4'h2); press(4'h3);
    enter = 1'b1;
    keyStrobe = 1'b1;
    keyDigit = 4'h4;
    tick();
    enter = 1'b0;
    keyStrobe = 1'b0;
    total++;
    if (userEntry !== 16'hE123) begin
      bad++;
      $display("FAIL bnd_enter_over_strobe got=%h want=E123", userEntry);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_change_code();
    type_code(16'h1234);
    pulse_enter();
    tick();
    type_code(16'h9876);
    total++;
    if (unlocked !== 1'b1 || userEntry !== 16'h9876) begin
      bad++;
      $display("FAIL chg_entry got=%b/%h want=1/9876", unlocked, userEntry);
    end
    pulse_enter();
    total++;
    if (unlocked !== 1'b0 || userEntry !== 16'hEEEE) begin
      bad++;
      $display("FAIL chg_store got=%b/%h want=0/EEEE", unlocked, userEntry);
    end
    type_code(16'h1234);
    pulse_enter();
    tick();
    total++;
    if (error !== 1'b1 || unlocked !== 1'b0) begin
      bad++;
      $display("FAIL chg_old_rejected got=%b/%b want=1/0", error, unlocked);
    end
    repeat (8) tick();
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL chg_error_end got=%b want=0", error);
    end
    type_code(16'h9876);
    pulse_enter();
    tick();
    total++;
    if (unlocked !== 1'b1) begin
      bad++;
      $display("FAIL chg_new_accepted got=%b want=1", unlocked);
    end
    // lockCmd beats enter: the new entry must not be stored
    type_code(16'h1111);
    lockCmd = 1'b1;
    enter = 1'b1;
    tick();
    lockCmd = 1'b0;
    enter = 1'b0;
    total++;
    if (unlocked !== 1'b0 || userEntry !== 16'hEEEE) begin
      bad++;
      $display("FAIL chg_lock_over_enter got=%b/%h want=0/EEEE", unlocked, userEntry);
    end
    type_code(16'h9876);
    pulse_enter();
    tick();
    total++;
    if (unlocked !== 1'b1) begin
      bad++;
      $display("FAIL chg_code_kept got=%b want=1", unlocked);
    end
    pulse_lock();
    total++;
    if (unlocked !== 1'b0) begin
      bad++;
      $display("FAIL chg_relock got=%b want=0", unlocked);
    end
  endtask

  task automatic test_async_reset();
    type_code(16'h1234);
    pulse_enter();
    tick();
    tick();
    tick();
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL arst_in_error got=%b want=1", error);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (error !== 1'b0 || userEntry !== 16'hEEEE) begin
      bad++;
      $display("FAIL arst_immediate got=%b/%h want=0/EEEE", error, userEntry);
    end
    #1;
    reset = 1'b0;
    tick();
    type_code(16'h1234);
    pulse_enter();
    tick();
    total++;
    if (unlocked !== 1'b1) begin
      bad++;
      $display("FAIL arst_default_code got=%b want=1", unlocked);
    end
    pulse_lock();
  endtask

`ifdef LOCKOUT_EN
  task automatic test_lockout();
    for (int n = 0; n < 2; n++) begin
      type_code(16'h5555);
      pulse_enter();
      repeat (9) tick();
      total++;
      if (error !== 1'b0 || lockedOut !== 1'b0) begin
        bad++;
        $display("FAIL lko_try%0d got=%b/%b want=0/0", n, error, lockedOut);
      end
    end
    type_code(16'h5555);
    pulse_enter();
    repeat (8) tick();
    for (int i = 0; i < 16; i++) begin
      press(4'h1);
      total++;
      if (lockedOut !== 1'b1 || error !== 1'b1 || userEntry !== 16'hEEEE) begin
        bad++;
        $display("FAIL lko_hold%0d got=%b/%b/%h want=1/1/EEEE", i, lockedOut, error, userEntry);
      end
    end
    tick();
    total++;
    if (lockedOut !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL lko_release got=%b/%b want=0/0", lockedOut, error);
    end
    type_code(16'h1234);
    pulse_enter();
    tick();
    total++;
    if (unlocked !== 1'b1) begin
      bad++;
      $display("FAIL lko_unlock_after got=%b want=1", unlocked);
    end
    pulse_lock();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    keyStrobe = 1'b0;
    keyDigit  = 4'h0;
    enter     = 1'b0;
    clear     = 1'b0;
    lockCmd   = 1'b0;
    test_reset();
    test_unlock();
    test_error();
    test_boundary();
    test_change_code();
    test_async_reset();
`ifdef LOCKOUT_EN
    test_lockout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
